data_sram_responder: RTL and testbench

//  Responder end of the core's data_sram interface: serves the data_sram_en/wen/addr/wdata requests the pipeline issues and

---
 rtl/data_sram_if.sv | 11 +
 rtl/data_sram_responder.sv | 149 ++++++++++++++
 tb/tb_data_sram_responder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/data_sram_if.sv
// Core-side data_sram bus: one request per cycle, read data returned one cycle later.
interface data_sram_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, wen, addr, wdata, input rdata);
  modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_responder.sv
// Responder for the core's data_sram port: word-addressed RAM plus an MMIO window
// (LED, synchronised switch, free-running timer, scratch), fixed one-cycle read latency.
module data_sram_responder #(
  parameter int unsigned ADDR_W  = 14,
  parameter logic [15:0] MMIO_HI = 16'hBFAF,
  parameter int unsigned LED_W   = 16,
  parameter int unsigned SW_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  data_sram_if.slave        bus,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   switch
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_LED,
    TGT_SWITCH,
    TGT_TIMER,
    TGT_SCRATCH,
    TGT_NONE
  } target_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0]       ram_q [RAM_DEPTH];
  logic [31:0]       ram_rdata_q;
  logic [ADDR_W-1:0] ram_idx;
  logic              ram_we, ram_re;

  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       timer_q, timer_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [SW_W-1:0]   sw_meta_q, sw_meta_d;
  logic [SW_W-1:0]   sw_sync_q, sw_sync_d;
  logic [31:0]       mmio_rdata_q, mmio_rdata_d;
  logic              rd_ram_q, rd_ram_d;

  target_e           target;
  logic              req_valid, is_write;
  logic [31:0]       led_merged;
  logic [1:0]        addr_unused;

  // Byte offset bits carry no meaning on a word bus.
  assign addr_unused = bus.addr[1:0];

  assign req_valid = bus.en && !rst;
  assign is_write  = |bus.wen;
  assign ram_idx   = bus.addr[ADDR_W+1:2];
  assign ram_we    = req_valid &&  is_write && (target == TGT_RAM);
  assign ram_re    = req_valid && !is_write && (target == TGT_RAM);

  always_comb begin
    target = TGT_RAM;
    if (bus.addr[31:16] == MMIO_HI) begin
      unique case (bus.addr[15:2])
        14'd0:   target = TGT_LED;
        14'd1:   target = TGT_SWITCH;
        14'd2:   target = TGT_TIMER;
        14'd3:   target = TGT_SCRATCH;
        default: target = TGT_NONE;
      endcase
    end
  end

  // NOTE: block RAM cannot be cleared in one cycle, so the array has no reset;
  // rd_ram_q masks the read register until a real RAM read has happened.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wen[i]) ram_q[ram_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
    if (ram_re) ram_rdata_q <= ram_q[ram_idx];
  end

  assign led_merged = byte_merge(32'(led_q), bus.wdata, bus.wen);

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    led_d        = led_q;
    timer_d      = timer_q + 32'd1;
    scratch_d    = scratch_q;
    sw_meta_d    = switch;
    sw_sync_d    = sw_meta_q;
    mmio_rdata_d = mmio_rdata_q;
    rd_ram_d     = rd_ram_q;

    if (req_valid) begin
      if (is_write) begin
        unique case (target)
          TGT_LED:     led_d     = led_merged[LED_W-1:0];
          TGT_TIMER:   timer_d   = byte_merge(timer_q, bus.wdata, bus.wen);
          TGT_SCRATCH: scratch_d = byte_merge(scratch_q, bus.wdata, bus.wen);
          default:     ;
        endcase
      end else begin
        rd_ram_d = (target == TGT_RAM);
        unique case (target)
          TGT_LED:     mmio_rdata_d = 32'(led_q);
          TGT_SWITCH:  mmio_rdata_d = 32'(sw_sync_q);
          TGT_TIMER:   mmio_rdata_d = timer_q;
          TGT_SCRATCH: mmio_rdata_d = scratch_q;
          TGT_NONE:    mmio_rdata_d = '0;
          default:     ;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q        <= '0;
      timer_q      <= '0;
      scratch_q    <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      mmio_rdata_q <= '0;
      rd_ram_q     <= 1'b0;
    end else begin
      led_q        <= led_d;
      timer_q      <= timer_d;
      scratch_q    <= scratch_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      mmio_rdata_q <= mmio_rdata_d;
      rd_ram_q     <= rd_ram_d;
    end
  end

  assign bus.rdata = rd_ram_q ? ram_rdata_q : mmio_rdata_q;
  assign led       = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: reads push expected data into a scoreboard
// queue, a monitor pops and compares one cycle after each accepted read.
module tb_data_sram_responder;

  localparam logic [31:0] A_LED   = 32'hBFAF_0000;
  localparam logic [31:0] A_SW    = 32'hBFAF_0004;
  localparam logic [31:0] A_TIMER = 32'hBFAF_0008;
  localparam logic [31:0] A_SCR   = 32'hBFAF_000C;
  localparam logic [31:0] A_HOLE  = 32'hBFAF_0020;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_next;
  logic [15:0] led;
  logic [7:0]  switch;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  data_sram_if bus();

  data_sram_responder dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .led    (led),
    .switch (switch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    rst       = rst_next;
    bus.en    = en;
    bus.wen   = wen;
    bus.addr  = addr;
    bus.wdata = wdata;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data);
    drive(1'b1, wen, addr, data);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b1, 4'h0, addr, 32'h0);
    if (!rst) exp_q.push_back('{tag, exp});
  endtask

  // en=0 with a live-looking write to scratch: must have no effect.
  task automatic idle();
    drive(1'b0, 4'hF, A_SCR, 32'hFFFF_FFFF);
  endtask

  // Monitor: a read accepted at a rising edge is checked at the following falling edge.
  initial begin
    logic rd_seen;
    exp_t e;
    forever begin
      @(posedge clk);
      rd_seen = bus.en && (bus.wen == 4'h0) && !rst;
      @(negedge clk);
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got %h expected no read", bus.rdata);
        end else begin
          e = exp_q.pop_front();
          check(e.tag, bus.rdata, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst_next = 1'b1; switch = 8'h00;
    bus.en = 1'b0; bus.wen = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;

    // Reset: requests dropped, rdata and led stay 0, timer starts at 0.
    rd("rst_ram0", 32'h0, 32'h0);
    rd("rst_tmr", A_TIMER, 32'h0);
    rd("rst_ram0b", 32'h0, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_led", 32'(led), 32'h0);
    rst_next = 1'b0;
    rd("tmr_first", A_TIMER, 32'h0);

    // RAM full-word and byte-lane writes, aliasing.
    wr(32'h100, 4'hF, 32'hDEAD_BEEF);
    rd("ram_full", 32'h100, 32'hDEAD_BEEF);
    wr(32'h100, 4'b0010, 32'h0000_5500);
    idle();
    check("wr_hold", bus.rdata, 32'hDEAD_BEEF);
    rd("ram_lane", 32'h100, 32'hDEAD_55EF);
    rd("ram_alias", 32'h0001_0100, 32'hDEAD_55EF);
    wr(32'h104, 4'hF, 32'h0000_0000);
    wr(32'h104, 4'b1001, 32'hAABB_CCDD);
    rd("ram_lanes2", 32'h104, 32'hAA00_00DD);

    // LED register, upper-bit discard, unmapped offset.
    wr(32'h20, 4'hF, 32'hCAFE_F00D);
    wr(A_LED, 4'hF, 32'h1234_ABCD);
    idle();
    check("led_upd", 32'(led), 32'h0000_ABCD);
    rd("led_rd", A_LED, 32'h0000_ABCD);
    wr(A_LED, 4'b1100, 32'hFFFF_0000);
    rd("led_upper", A_LED, 32'h0000_ABCD);
    wr(A_HOLE, 4'hF, 32'hFFFF_FFFF);
    rd("mmio_hole", A_HOLE, 32'h0);
    rd("hole_no_ram", 32'h20, 32'hCAFE_F00D);

    // Scratch with lane merge; en=0 cycles leave rdata and state alone.
    wr(A_SCR, 4'hF, 32'hA5A5_A5A5);
    wr(A_SCR, 4'b1100, 32'h1234_0000);
    rd("scratch", A_SCR, 32'h1234_A5A5);
    idle();
    idle();
    check("en0_hold", bus.rdata, 32'h1234_A5A5);
    rd("scratch_en0", A_SCR, 32'h1234_A5A5);

    // Timer load, wrap, byte-merged load.
    wr(A_TIMER, 4'hF, 32'hFFFF_FFFE);
    idle();
    rd("tmr_max", A_TIMER, 32'hFFFF_FFFF);
    rd("tmr_wrap", A_TIMER, 32'h0);
    wr(A_TIMER, 4'b0001, 32'h0000_00AA);
    rd("tmr_merge", A_TIMER, 32'h0000_00AA);

    // Switch synchroniser latency and read-only behaviour.
    idle();
    switch = 8'h5A;
    rd("sw_old", A_SW, 32'h0);
    rd("sw_new", A_SW, 32'h0000_005A);
    wr(A_SW, 4'hF, 32'hFFFF_FFFF);
    rd("sw_ro", A_SW, 32'h0000_005A);

    // Write under reset is dropped; RAM keeps contents, MMIO clears.
    wr(32'h200, 4'hF, 32'h2222_2222);
    rst_next = 1'b1;
    wr(32'h200, 4'hF, 32'h1111_1111);
    idle();
    idle();
    check("rst2_rdata", bus.rdata, 32'h0);
    check("rst2_led", 32'(led), 32'h0);
    rst_next = 1'b0;
    rd("rst_keep", 32'h200, 32'h2222_2222);
    rd("tmr_after_rst", A_TIMER, 32'h1);
    rd("scr_after_rst", A_SCR, 32'h0);

    idle();
    idle();
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
